// File: rtl/cpu_regfile_sb.sv
// CPU register file: two read ports, one write port and a per-register busy scoreboard.
// Define CPU_REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports and reg0_data.
module cpu_regfile_sb #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SEL_W-1:0]  rd_a_sel,
    input  logic              rd_a_oe,
    output logic [DATA_W-1:0] rd_a_data,
    output logic              rd_a_busy,
    input  logic [SEL_W-1:0]  rd_b_sel,
    input  logic              rd_b_oe,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              rd_b_busy,
    input  logic              rsv_en,
    input  logic [SEL_W-1:0]  rsv_sel,
    output logic              rsv_ok,
    output logic [NREGS-1:0]  busy_vec,
    output logic [DATA_W-1:0] reg0_data
);

`ifdef CPU_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic              wr_live;
    logic              byp_a;
    logic              byp_b;
    logic              byp_0;

    // A write in the reset cycle is discarded, so it must not be forwarded either.
    assign wr_live = wr_en & ~rst;
    assign byp_a   = BYPASS & wr_live & (wr_sel == rd_a_sel);
    assign byp_b   = BYPASS & wr_live & (wr_sel == rd_b_sel);
    assign byp_0   = BYPASS & wr_live & (wr_sel == SEL_W'(0));

    // A same-index writeback retires the current owner, so the reserve can take over.
    assign rsv_ok = rsv_en & (~busy_q[rsv_sel] | (wr_en & (wr_sel == rsv_sel)));

    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_sel] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            if (wr_en) begin
                regs_q[wr_sel] <= wr_data;
            end
        end
    end

    assign rd_a_data = rd_a_oe ? (byp_a ? wr_data : regs_q[rd_a_sel]) : '0;
    assign rd_b_data = rd_b_oe ? (byp_b ? wr_data : regs_q[rd_b_sel]) : '0;
    assign rd_a_busy = busy_q[rd_a_sel] & ~byp_a;
    assign rd_b_busy = busy_q[rd_b_sel] & ~byp_b;
    assign busy_vec  = busy_q;
    assign reg0_data = byp_0 ? wr_data : regs_q[0];

endmodule

// File: tb/tb_cpu_regfile_sb.sv
// Directed testbench for cpu_regfile_sb: expectations are queued when stimulus is applied
// and popped in order when the outputs are sampled.
module tb_cpu_regfile_sb;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned SEL_W  = 3;

`ifdef CPU_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [SEL_W-1:0]  rd_a_sel;
    logic              rd_a_oe;
    logic [DATA_W-1:0] rd_a_data;
    logic              rd_a_busy;
    logic [SEL_W-1:0]  rd_b_sel;
    logic              rd_b_oe;
    logic [DATA_W-1:0] rd_b_data;
    logic              rd_b_busy;
    logic              rsv_en;
    logic [SEL_W-1:0]  rsv_sel;
    logic              rsv_ok;
    logic [NREGS-1:0]  busy_vec;
    logic [DATA_W-1:0] reg0_data;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    cpu_regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_a_sel(rd_a_sel), .rd_a_oe(rd_a_oe), .rd_a_data(rd_a_data), .rd_a_busy(rd_a_busy),
        .rd_b_sel(rd_b_sel), .rd_b_oe(rd_b_oe), .rd_b_data(rd_b_data), .rd_b_busy(rd_b_busy),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_ok(rsv_ok),
        .busy_vec(busy_vec), .reg0_data(reg0_data)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, required an expectation", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        rd_a_sel = '0; rd_a_oe = 1'b1; rd_b_sel = '0; rd_b_oe = 1'b1;
        rsv_en = 1'b0; rsv_sel = '0;

        // Reset state
        tick();
        rsv_en = 1'b1; rsv_sel = 3'd2;
        push("rst_rsv_ok", 32'd1); push("rst_busy_vec", 32'd0);
        push("rst_reg0", 32'd0);   push("rst_rd_a", 32'd0);
        #1;
        check(32'(rsv_ok)); check(32'(busy_vec)); check(32'(reg0_data)); check(32'(rd_a_data));
        rsv_en = 1'b0; rst = 1'b0;

        // Write / read
        tick(); wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hBEEF;
        tick(); wr_sel = 3'd5; wr_data = 16'h1234;
        tick(); wr_en = 1'b0; rd_a_sel = 3'd3; rd_b_sel = 3'd5;
        push("rd_a_r3", 32'hBEEF); push("rd_b_r5", 32'h1234);
        #1; check(32'(rd_a_data)); check(32'(rd_b_data));
        rd_a_oe = 1'b0;
        push("rd_a_oe0", 32'h0); push("rd_b_still", 32'h1234);
        #1; check(32'(rd_a_data)); check(32'(rd_b_data));
        rd_a_oe = 1'b1;

        // Scoreboard: reserve, refuse, release by write
        tick(); rsv_en = 1'b1; rsv_sel = 3'd2;
        push("rsv_r2_ok", 32'd1); push("rsv_r2_busy_pre", 32'h00);
        #1; check(32'(rsv_ok)); check(32'(busy_vec));
        tick(); rd_b_sel = 3'd2;
        push("rsv_r2_again_ok", 32'd0); push("busy_r2", 32'h04); push("rd_b_busy_r2", 32'd1);
        #1; check(32'(rsv_ok)); check(32'(busy_vec)); check(32'(rd_b_busy));
        tick(); rsv_en = 1'b0;
        push("busy_r2_kept", 32'h04);
        #1; check(32'(busy_vec));
        wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'h0042;
        push("rd_b_busy_wr", BYPASS ? 32'd0 : 32'd1);
        #1; check(32'(rd_b_busy));
        tick(); wr_en = 1'b0;
        push("busy_cleared", 32'h00); push("rd_b_r2", 32'h0042); push("rd_b_busy_clr", 32'd0);
        #1; check(32'(busy_vec)); check(32'(rd_b_data)); check(32'(rd_b_busy));

        // Collision on a busy register
        tick(); rsv_en = 1'b1; rsv_sel = 3'd4;
        push("rsv_r4_ok", 32'd1);
        #1; check(32'(rsv_ok));
        tick(); wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'hAAAA;
        push("coll_busy_rsv_ok", 32'd1); push("coll_busy_pre", 32'h10);
        #1; check(32'(rsv_ok)); check(32'(busy_vec));
        tick(); rsv_en = 1'b0; wr_en = 1'b0; rd_a_sel = 3'd4;
        push("coll_busy_vec", 32'h10); push("coll_rd_r4", 32'hAAAA); push("coll_rd_a_busy", 32'd1);
        #1; check(32'(busy_vec)); check(32'(rd_a_data)); check(32'(rd_a_busy));

        // Collision on a free register
        rsv_en = 1'b1; rsv_sel = 3'd6; wr_en = 1'b1; wr_sel = 3'd6; wr_data = 16'h5A5A;
        push("coll_free_rsv_ok", 32'd1);
        #1; check(32'(rsv_ok));
        tick(); rsv_en = 1'b0; wr_en = 1'b0; rd_b_sel = 3'd6;
        push("coll_free_busy", 32'h50); push("coll_free_rd", 32'h5A5A);
        #1; check(32'(busy_vec)); check(32'(rd_b_data));

        // Same-cycle read of a register being written
        rd_a_sel = 3'd1; wr_en = 1'b1; wr_sel = 3'd1; wr_data = 16'h5555;
        push("bypass_same_cycle", BYPASS ? 32'h5555 : 32'h0000);
        #1; check(32'(rd_a_data));
        tick(); wr_en = 1'b0;
        push("bypass_next_cycle", 32'h5555);
        #1; check(32'(rd_a_data));

        // reg0 export while read ports look elsewhere
        rd_a_sel = 3'd3; rd_b_sel = 3'd5; wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'h00FF;
        push("reg0_same_cycle", BYPASS ? 32'h00FF : 32'h0000);
        #1; check(32'(reg0_data));
        tick(); wr_en = 1'b0;
        push("reg0_data", 32'h00FF); push("reg0_rd_a", 32'hBEEF); push("reg0_rd_b", 32'h1234);
        #1; check(32'(reg0_data)); check(32'(rd_a_data)); check(32'(rd_b_data));

        // Mid-run reset with a write and reserve in flight
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 16'h7777; rsv_en = 1'b1; rsv_sel = 3'd7; rst = 1'b1;
        push("mid_rst_busy", 32'h00); push("mid_rst_reg0", 32'h0); push("mid_rst_rd_a", 32'h0);
        push("mid_rst_rd_b", 32'h0); push("mid_rst_rsv_ok", 32'd1);
        #1; check(32'(busy_vec)); check(32'(reg0_data)); check(32'(rd_a_data));
        check(32'(rd_b_data)); check(32'(rsv_ok));
        tick(); rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0; rd_a_sel = 3'd7;
        push("post_rst_r7", 32'h0); push("post_rst_busy", 32'h00);
        #1; check(32'(rd_a_data)); check(32'(busy_vec));

        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL scoreboard_leftover: %0d expectations never compared, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
